// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, branch compare and an iterative
// shift-add multiplier that stalls upstream while it runs.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = XLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] data_in_1,
    input  logic [XLEN-1:0] data_in_2,
    input  logic [XLEN-1:0] imm_in,
    input  logic [4:0]      rd_in,
    input  logic            alusrc_in,
    input  logic            pcsrc_in,
    input  logic            memtoreg_in,
    input  logic            we_in,
    input  logic            reg_en_in,
    output logic            stall,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_out,
    output logic            memtoreg_out,
    output logic            we_out,
    output logic            reg_en_out,
    output logic            branch_taken
);

    localparam int CW = $clog2(MUL_STEPS + 1);
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] ma_q, ma_d;
    logic [XLEN-1:0] mb_q, mb_d;
    logic [XLEN-1:0] borig_q, borig_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      lrd_q, lrd_d;
    logic            lmtr_q, lmtr_d;
    logic            lwe_q, lwe_d;
    logic            lren_q, lren_d;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] st_q, st_d;
    logic [4:0]      rd_q, rd_d;
    logic            mtr_q, mtr_d;
    logic            we_q, we_d;
    logic            ren_q, ren_d;
    logic            br_q, br_d;

    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            is_mul;
    logic            eq;

    assign op_b   = alusrc_in ? imm_in : data_in_2;
    assign shamt  = op_b[4:0];
    assign is_mul = (alu_op == OP_MUL);
    assign eq     = (data_in_1 == data_in_2);

    // MUL encodes as 0 here; its product only comes from the iterative unit.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0: alu_res = data_in_1 + op_b;
            4'd1: alu_res = data_in_1 - op_b;
            4'd2: alu_res = data_in_1 & op_b;
            4'd3: alu_res = data_in_1 | op_b;
            4'd4: alu_res = data_in_1 ^ op_b;
            4'd5: alu_res = data_in_1 << shamt;
            4'd6: alu_res = data_in_1 >> shamt;
            4'd7: alu_res = $unsigned($signed(data_in_1) >>> shamt);
            4'd8: alu_res = {{(XLEN-1){1'b0}},
                             ($signed(data_in_1) < $signed(op_b))};
            4'd9: alu_res = {{(XLEN-1){1'b0}}, (data_in_1 < op_b)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        borig_d = borig_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        lrd_d   = lrd_q;
        lmtr_d  = lmtr_q;
        lwe_d   = lwe_q;
        lren_d  = lren_q;
        stall   = 1'b0;
        valid_d = 1'b0;
        res_d   = alu_res;
        st_d    = data_in_2;
        rd_d    = rd_in;
        mtr_d   = 1'b0;
        we_d    = 1'b0;
        ren_d   = 1'b0;
        br_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in && is_mul) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    ma_d    = data_in_1;
                    mb_d    = op_b;
                    borig_d = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    lrd_d   = rd_in;
                    lmtr_d  = memtoreg_in;
                    lwe_d   = we_in;
                    lren_d  = reg_en_in;
                end else if (valid_in) begin
                    valid_d = 1'b1;
                    mtr_d   = memtoreg_in;
                    we_d    = we_in;
                    ren_d   = reg_en_in;
                    br_d    = pcsrc_in & eq;
                end
            end
            BUSY: begin
                stall = 1'b1;
                acc_d = acc_q + (mb_q[0] ? ma_q : '0);
                ma_d  = ma_q << 1;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
                res_d   = acc_q;
                st_d    = borig_q;
                rd_d    = lrd_q;
                mtr_d   = lmtr_q;
                we_d    = lwe_q;
                ren_d   = lren_q;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            stall   = 1'b0;
            state_d = IDLE;
            valid_d = 1'b0;
            mtr_d   = 1'b0;
            we_d    = 1'b0;
            ren_d   = 1'b0;
            br_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            borig_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            lrd_q   <= '0;
            lmtr_q  <= 1'b0;
            lwe_q   <= 1'b0;
            lren_q  <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
            st_q    <= '0;
            rd_q    <= '0;
            mtr_q   <= 1'b0;
            we_q    <= 1'b0;
            ren_q   <= 1'b0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            borig_q <= borig_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            lrd_q   <= lrd_d;
            lmtr_q  <= lmtr_d;
            lwe_q   <= lwe_d;
            lren_q  <= lren_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            st_q    <= st_d;
            rd_q    <= rd_d;
            mtr_q   <= mtr_d;
            we_q    <= we_d;
            ren_q   <= ren_d;
            br_q    <= br_d;
        end
    end

    assign valid_out    = valid_q;
    assign alu_result   = res_q;
    assign store_data   = st_q;
    assign rd_out       = rd_q;
    assign memtoreg_out = mtr_q;
    assign we_out       = we_q;
    assign reg_en_out   = ren_q;
    assign branch_taken = br_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table, flush/reset sequences and
// randomized ops against an arithmetic reference model.
module tb_ex_stage;

    logic        clock;
    logic        reset_n;
    logic        valid_in;
    logic        flush;
    logic [3:0]  alu_op;
    logic [31:0] data_in_1;
    logic [31:0] data_in_2;
    logic [31:0] imm_in;
    logic [4:0]  rd_in;
    logic        alusrc_in;
    logic        pcsrc_in;
    logic        memtoreg_in;
    logic        we_in;
    logic        reg_en_in;
    logic        stall;
    logic        valid_out;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_out;
    logic        memtoreg_out;
    logic        we_out;
    logic        reg_en_out;
    logic        branch_taken;

    int checks = 0;
    int errors = 0;
    int sc;
    bit sawv;

    ex_stage #(.XLEN(32), .MUL_STEPS(32)) dut (
        .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
        .flush(flush), .alu_op(alu_op), .data_in_1(data_in_1),
        .data_in_2(data_in_2), .imm_in(imm_in), .rd_in(rd_in),
        .alusrc_in(alusrc_in), .pcsrc_in(pcsrc_in),
        .memtoreg_in(memtoreg_in), .we_in(we_in),
        .reg_en_in(reg_en_in), .stall(stall), .valid_out(valid_out),
        .alu_result(alu_result), .store_data(store_data),
        .rd_out(rd_out), .memtoreg_out(memtoreg_out), .we_out(we_out),
        .reg_en_out(reg_en_out), .branch_taken(branch_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        als, pcs, vin;
        logic [4:0]  rd;
        logic [31:0] er;
        logic        ev, eb;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic exec(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm,
                        input logic als, input logic pcs,
                        input logic vin, input logic [4:0] rd);
        alu_op = op; data_in_1 = a; data_in_2 = b; imm_in = imm;
        alusrc_in = als; pcsrc_in = pcs; valid_in = vin; rd_in = rd;
        #1;
        sc = 0;
        sawv = 0;
        while (stall && sc < 100) begin
            @(posedge clock); #1;
            sc++;
            if (valid_out) sawv = 1;
        end
        @(posedge clock); #1;
    endtask

    task automatic check_all(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm,
                             input logic als, input logic pcs,
                             input logic vin, input logic [4:0] rd);
        logic [31:0] opb;
        opb = als ? imm : b;
        chk("rnd_valid", {31'd0, valid_out}, {31'd0, vin});
        if (vin) begin
            chk("rnd_result", alu_result, ref_alu(op, a, opb));
            chk("rnd_rd", {27'd0, rd_out}, {27'd0, rd});
            chk("rnd_store", store_data, (op == 4'd10) ? opb : b);
            chk("rnd_branch", {31'd0, branch_taken},
                {31'd0, (op != 4'd10) && pcs && (a == b)});
            chk("rnd_we", {31'd0, we_out}, 32'd1);
        end else begin
            chk("rnd_bubble_br", {31'd0, branch_taken}, 32'd0);
            chk("rnd_bubble_we", {31'd0, we_out}, 32'd0);
        end
        if (vin && op == 4'd10) begin
            chk("rnd_mul_stall", sc, 33);
            chk("rnd_mul_early", {31'd0, sawv}, 32'd0);
        end else begin
            chk("rnd_nostall", sc, 0);
        end
    endtask

    initial begin
        bit seen;
        logic [3:0]  rop;
        logic [31:0] ra, rb, rimm;
        logic        rals, rpcs, rvin;
        logic [4:0]  rrd;

        tbl[0] = '{4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3,
                   32'd12, 1'b1, 1'b0};
        tbl[1] = '{4'd7, 32'h80000000, 32'd0, 32'd4, 1'b1, 1'b0, 1'b1,
                   5'd4, 32'hF8000000, 1'b1, 1'b0};
        tbl[2] = '{4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1,
                   5'd5, 32'd1, 1'b1, 1'b0};
        tbl[3] = '{4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1,
                   5'd6, 32'd0, 1'b1, 1'b0};
        tbl[4] = '{4'd10, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1,
                   5'd7, 32'hFFFFFFFD, 1'b1, 1'b0};
        tbl[5] = '{4'd0, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, 5'd8,
                   32'd18, 1'b1, 1'b1};
        tbl[6] = '{4'd0, 32'd9, 32'd8, 32'd0, 1'b0, 1'b1, 1'b1, 5'd9,
                   32'd17, 1'b1, 1'b0};
        tbl[7] = '{4'd0, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0, 5'd10,
                   32'd18, 1'b0, 1'b0};
        tbl[8] = '{4'd1, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 5'd11,
                   32'hFFFFFFFE, 1'b1, 1'b0};
        tbl[9] = '{4'd5, 32'd1, 32'd0, 32'd31, 1'b1, 1'b0, 1'b1, 5'd12,
                   32'h80000000, 1'b1, 1'b0};

        reset_n = 1'b0; valid_in = 1'b0; flush = 1'b0; alu_op = 4'd0;
        data_in_1 = '0; data_in_2 = '0; imm_in = '0; rd_in = '0;
        alusrc_in = 1'b0; pcsrc_in = 1'b0; memtoreg_in = 1'b0;
        we_in = 1'b1; reg_en_in = 1'b1;
        #12;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) begin
            exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].als,
                 tbl[i].pcs, tbl[i].vin, tbl[i].rd);
            chk($sformatf("tbl%0d_valid", i), {31'd0, valid_out},
                {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_branch", i), {31'd0, branch_taken},
                {31'd0, tbl[i].eb});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_result", i), alu_result, tbl[i].er);
                chk($sformatf("tbl%0d_rd", i), {27'd0, rd_out},
                    {27'd0, tbl[i].rd});
            end
            if (tbl[i].op == 4'd10) begin
                chk("tbl_mul_stall_cycles", sc, 33);
                chk("tbl_mul_no_early_valid", {31'd0, sawv}, 32'd0);
            end else begin
                chk($sformatf("tbl%0d_stall", i), {31'd0, stall}, 32'd0);
            end
        end

        // flush at BUSY count 10
        alu_op = 4'd10; data_in_1 = 32'd123; data_in_2 = 32'd456;
        alusrc_in = 1'b0; pcsrc_in = 1'b0; valid_in = 1'b1; rd_in = 5'd2;
        #1;
        repeat (11) begin @(posedge clock); #1; end
        chk("flush_pre_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall_low", {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        flush = 1'b0; valid_in = 1'b0;
        #1;
        chk("flush_idle_stall", {31'd0, stall}, 32'd0);
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        seen = 0;
        repeat (40) begin @(posedge clock); #1; if (valid_out) seen = 1; end
        chk("flush_no_product", {31'd0, seen}, 32'd0);
        exec(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1);
        chk("flush_add_result", alu_result, 32'd2);
        chk("flush_add_valid", {31'd0, valid_out}, 32'd1);
        chk("flush_add_stall", sc, 0);

        // asynchronous reset mid-MUL
        alu_op = 4'd10; data_in_1 = 32'h1234; data_in_2 = 32'h55;
        valid_in = 1'b1; rd_in = 5'd7;
        #1;
        repeat (6) begin @(posedge clock); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rd", {27'd0, rd_out}, 32'd0);
        chk("arst_store", store_data, 32'd0);
        chk("arst_result", alu_result, 32'd0);
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        valid_in = 1'b0;
        #3;
        reset_n = 1'b1;
        @(posedge clock); #1;
        seen = 0;
        repeat (40) begin @(posedge clock); #1; if (valid_out) seen = 1; end
        chk("arst_no_stale", {31'd0, seen}, 32'd0);
        exec(4'd10, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9);
        chk("arst_mul_result", alu_result, 32'd42);
        chk("arst_mul_valid", {31'd0, valid_out}, 32'd1);
        chk("arst_mul_stall", sc, 33);

        for (int n = 0; n < 200; n++) begin
            rop  = ($urandom_range(0, 7) == 0) ? 4'd10
                                               : 4'($urandom_range(0, 15));
            ra   = $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rimm = $urandom;
            rals = 1'($urandom_range(0, 1));
            rpcs = 1'($urandom_range(0, 1));
            rvin = ($urandom_range(0, 4) != 0);
            rrd  = 5'($urandom_range(0, 31));
            exec(rop, ra, rb, rimm, rals, rpcs, rvin, rrd);
            check_all(rop, ra, rb, rimm, rals, rpcs, rvin, rrd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RISC-V pipeline. It consumes the decode-to-execute register outputs and produces the registered execute-to-memory fields.
- Single-cycle ALU ops complete in one cycle.
- MUL runs on an iterative shift-add unit and stalls upstream while it runs.
- BEQ-style branch resolution is produced alongside the ALU result.

Parameters:
- XLEN, 32, datapath width.
- MUL_STEPS, XLEN, iterations of the radix-2 multiplier; fixed equal to XLEN.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- valid_in  input  1  the execute-stage input holds a real instruction.
- flush  input  1  synchronous kill of the current and in-flight instruction.
- alu_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL; 11-15 produce result 0.
- data_in_1  input  XLEN  rs1 value.
- data_in_2  input  XLEN  rs2 value.
- imm_in  input  XLEN  immediate.
- rd_in  input  5  destination register.
- alusrc_in  input  1  operand B select: 1 = imm_in, 0 = data_in_2.
- pcsrc_in  input  1  instruction is a branch.
- memtoreg_in, we_in, reg_en_in  input  1 each  control bits passed through.
- stall  output  1  combinational; upstream holds its execute-stage inputs while stall is 1.
- valid_out  output  1  registered; the output fields hold a real instruction.
- alu_result  output  XLEN  registered result.
- store_data  output  XLEN  registered data_in_2.
- rd_out  output  5  registered.
- memtoreg_out, we_out, reg_en_out  output  1 each  registered.
- branch_taken  output  1  registered: pcsrc & (data_in_1 == data_in_2).

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - All outputs 0, FSM in IDLE, multiplier registers 0.
  - Assertion mid-MUL aborts the operation; no result is ever emitted.
- Operand B = alusrc_in ? imm_in : data_in_2.
- Shifts use B[4:0].
- SRA is arithmetic.
- SLT compares signed; SLTU compares unsigned. Each yields 0 or 1.
- ADD, SUB and MUL wrap modulo 2^XLEN. MUL produces the low XLEN bits of the product.
- FSM states: IDLE, BUSY, DONE.
- IDLE, single-cycle op:
  - Stays in IDLE.
  - On the edge, the output registers capture the result and control fields.
  - valid_out = valid_in & ~flush.
  - Latency is 1 cycle; throughput is 1 per cycle.
- IDLE, valid_in & alu_op==10 & ~flush:
  - stall = 1 combinationally.
  - On the edge: latch A, B, rd and the control bits; acc=0; count=0; go to BUSY.
  - The output registers load a bubble (valid_out=0, all write enables 0).
- BUSY:
  - stall = 1.
  - Each edge: if B[0], acc += A; then A <<= 1, B >>= 1, count++.
  - After MUL_STEPS edges (count reaches MUL_STEPS), go to DONE.
  - Outputs hold a bubble every edge.
  - data inputs are ignored in BUSY.
- DONE:
  - stall = 0.
  - On the edge: alu_result = acc, with the latched rd and control bits; valid_out=1; store_data = latched B original; branch_taken=0; go to IDLE.
  - Upstream advances on this same edge.
- MUL latency: valid_out rises on the 34th edge after the accepting edge is counted as edge 0 (1 accept + 32 BUSY + 1 DONE).
- flush:
  - Takes precedence over everything.
  - On the edge: valid_out=0, all write enables 0, branch_taken=0, FSM goes to IDLE.
  - While flush=1, stall=0.
- valid_in=0 in IDLE: the output registers load a bubble. branch_taken is gated by valid_in.
- Data fields of a bubble are don't-care, but must be deterministic (result of the input values).

Test Plan:
1. Reset release, then ADD with data_in_1=5, data_in_2=7, alusrc_in=0, rd_in=3 -> next edge: alu_result=12, rd_out=3, valid_out=1, stall=0.
2. SRA with data_in_1=0x80000000 and imm_in=4 (alusrc_in=1) -> alu_result=0xF8000000. SLT -1 vs 1 -> 1. SLTU with the same operands -> 0.
3. MUL 0xFFFFFFFF x 3 -> stall high for exactly 33 cycles; valid_out=1 with alu_result=0xFFFFFFFD on edge 34; no valid_out during the stall.
4. Branch: pcsrc_in=1, data 9==9 -> branch_taken=1. Data 9 vs 8 -> branch_taken=0. Same compare with valid_in=0 -> branch_taken=0.
5. Flush at BUSY count 10 -> next edge state IDLE, stall=0, valid_out=0. A following ADD 1+1 yields 2 one cycle later.
6. reset_n low mid-MUL -> outputs 0 immediately (asynchronous). After release, no stale product appears and a new MUL 6x7 yields 42.
